fire_dispatch_multi: RTL and testbench

//  Parametrised fire dispatcher between the axon stage and N synapse units. Accepts synapse

---
 rtl/ucaspian_dispatch_pkg.sv | 19 +
 rtl/range_fifo.sv | 45 ++++
 rtl/fire_dispatch_multi.sv | 145 ++++++++++++++
 tb/tb_fire_dispatch_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucaspian_dispatch_pkg.sv
// Shared types for the fire dispatcher: range record (sized for the widest supported index) and FSM state.
// Combinational only; no latency or backpressure of its own.
package ucaspian_dispatch_pkg;

    localparam int IDX_W_MAX = 32;

    typedef logic [IDX_W_MAX-1:0] gidx_t;

    typedef struct packed {
        gidx_t start_idx;
        gidx_t end_idx;
    } syn_range_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } dispatch_state_e;

endpackage

// File: rtl/range_fifo.sv
// Synchronous FIFO of syn_range_t; data visible at head one cycle after push, pop_dat is combinational.
// No internal protection: caller must not push when full nor pop when empty (gate with count).
module range_fifo
    import ucaspian_dispatch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  syn_range_t       push_dat,
    input  logic             pop,
    output syn_range_t       pop_dat,
    output logic [CNT_W-1:0] count
);

    syn_range_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/fire_dispatch_multi.sv
// Streams queued synapse index ranges one index per cycle to the unit chosen by the index MSBs; pop-to-valid 1 cycle, back-to-back ranges bubble-free.
// Valid holds until the selected unit's ready; input ready is enable & FIFO not full. FIRE_DISPATCH_STATS_EN adds fire_count.
module fire_dispatch_multi
    import ucaspian_dispatch_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int SYN_ADDR_W  = 10,
    parameter int RANGE_DEPTH = 2,
    localparam int SEL_W = $clog2(NUM_UNITS),
    localparam int IDX_W = SEL_W + SYN_ADDR_W
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    output logic                            step_done,
    input  logic [IDX_W-1:0]                syn_start,
    input  logic [IDX_W-1:0]                syn_end,
    input  logic                            syn_in_vld,
    output logic                            syn_in_rdy,
    output logic [NUM_UNITS-1:0]            syn_vld,
    output logic [NUM_UNITS*SYN_ADDR_W-1:0] syn_addr,
    input  logic [NUM_UNITS-1:0]            syn_rdy,
    output logic                            range_err
`ifdef FIRE_DISPATCH_STATS_EN
    ,
    output logic [31:0]                     fire_count
`endif
);

    localparam int CNT_W = $clog2(RANGE_DEPTH) + 1;

    syn_range_t      push_dat;
    syn_range_t      pop_dat;
    logic            push;
    logic            pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    dispatch_state_e state;
    dispatch_state_e state_next;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] cur_next;
    logic [IDX_W-1:0] last_next;
    logic [IDX_W-1:0] pop_start;
    logic [IDX_W-1:0] pop_end;
    logic [SEL_W-1:0] sel;
    logic             hs;
    logic             at_last;
    logic             bad_range;
    logic             rdy_q;

    assign push_dat   = '{start_idx: gidx_t'(syn_start), end_idx: gidx_t'(syn_end)};
    assign pop_start  = pop_dat.start_idx[IDX_W-1:0];
    assign pop_end    = pop_dat.end_idx[IDX_W-1:0];

    generate
        if (IDX_W < IDX_W_MAX) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^{pop_dat.start_idx[IDX_W_MAX-1:IDX_W], pop_dat.end_idx[IDX_W_MAX-1:IDX_W]};
        end
    endgenerate

    range_fifo #(.DEPTH(RANGE_DEPTH)) u_range_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .count    (count)
    );

    // rdy_q is the not-full view of the next count, so ready is low throughout reset
    assign syn_in_rdy = enable & rdy_q;
    assign push       = syn_in_vld & syn_in_rdy;

    assign sel       = cur_idx[IDX_W-1 -: SEL_W];
    assign hs        = (state == ISSUE) & syn_rdy[sel];
    assign at_last   = (cur_idx == last_idx);
    assign pop       = enable & (count != '0) & ((state == IDLE) | (hs & at_last));
    assign bad_range = (pop_start > pop_end);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_next = state;
        cur_next   = cur_idx;
        last_next  = last_idx;
        if (pop) begin
            if (bad_range) begin
                state_next = IDLE;
            end else begin
                state_next = ISSUE;
                cur_next   = pop_start;
                last_next  = pop_end;
            end
        end else if (hs) begin
            if (!at_last) begin
                cur_next = cur_idx + IDX_W'(1);
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_idx   <= '0;
            last_idx  <= '0;
            rdy_q     <= 1'b0;
            step_done <= 1'b1;
            range_err <= 1'b0;
        end else begin
            state     <= state_next;
            cur_idx   <= cur_next;
            last_idx  <= last_next;
            rdy_q     <= (count_next != CNT_W'(RANGE_DEPTH));
            step_done <= (state_next == IDLE) & (count_next == '0);
            if (pop && bad_range) begin
                range_err <= 1'b1;
            end
        end
    end

    always_comb begin
        syn_vld = '0;
        if (state == ISSUE) begin
            syn_vld[sel] = 1'b1;
        end
    end

    assign syn_addr = {NUM_UNITS{cur_idx[SYN_ADDR_W-1:0]}};

`ifdef FIRE_DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_count <= '0;
        end else if (hs && (fire_count != '1)) begin
            fire_count <= fire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fire_dispatch_multi.sv
// Directed bench for fire_dispatch_multi: stimulus pushes expected (unit, addr) pairs, a negedge monitor checks each handshake.
module tb_fire_dispatch_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        step_done;
    logic [11:0] syn_start;
    logic [11:0] syn_end;
    logic        syn_in_vld;
    logic        syn_in_rdy;
    logic [3:0]  syn_vld;
    logic [39:0] syn_addr;
    logic [3:0]  syn_rdy;
    logic        range_err;
`ifdef FIRE_DISPATCH_STATS_EN
    logic [31:0] fire_count;
`endif

    fire_dispatch_multi #(.NUM_UNITS(4), .SYN_ADDR_W(10), .RANGE_DEPTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .step_done  (step_done),
        .syn_start  (syn_start),
        .syn_end    (syn_end),
        .syn_in_vld (syn_in_vld),
        .syn_in_rdy (syn_in_rdy),
        .syn_vld    (syn_vld),
        .syn_addr   (syn_addr),
        .syn_rdy    (syn_rdy),
        .range_err  (range_err)
`ifdef FIRE_DISPATCH_STATS_EN
        ,
        .fire_count (fire_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unit;
        int addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_hs = -1;
    int   last_hs = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: handshake checking and stall stability
    logic [3:0] prev_vld;
    logic [9:0] prev_addr;
    bit         prev_stall = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            int   u;
            logic [9:0] a;
            exp_t e;
            cyc++;
            u = 0;
            if (prev_stall) begin
                chk("vld_hold", 32'(syn_vld), 32'(prev_vld));
                chk("addr_hold", 32'(syn_addr[9:0]), 32'(prev_addr));
            end
            prev_stall = 0;
            if (syn_vld != 4'd0) begin
                chk("onehot", 32'($onehot(syn_vld)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (syn_vld[i]) u = i;
                end
                a = syn_addr[u*10 +: 10];
                if (syn_rdy[u]) begin
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_hs unit %0d addr 0x%0h with nothing expected", u, a);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hs_unit", 32'(u), 32'(e.unit));
                        chk("hs_addr", 32'(a), 32'(e.addr));
                    end
                end else begin
                    prev_stall = 1;
                    prev_vld   = syn_vld;
                    prev_addr  = a;
                end
            end
        end
    end

    task automatic expect_hs(input int unit, input int addr);
        exp_t e;
        e.unit = unit;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [11:0] s, input logic [11:0] e);
        int  n = 0;
        bit  acc;
        syn_start  = s;
        syn_end    = e;
        syn_in_vld = 1'b1;
        forever begin
            @(negedge clk);
            acc = syn_in_rdy;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout syn_in_rdy stuck at %0b needed 1", syn_in_rdy);
                break;
            end
        end
        syn_in_vld = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit toggle);
        int n = 0;
        while (!(exp_q.size() == 0 && step_done === 1'b1)) begin
            @(posedge clk);
            #1;
            if (toggle) syn_rdy[2] = ~syn_rdy[2];
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout pending %0d step_done %0b expected 0 and 1", name, exp_q.size(), step_done);
                break;
            end
        end
        syn_rdy = 4'hF;
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b1;
        syn_start  = '0;
        syn_end    = '0;
        syn_in_vld = 1'b0;
        syn_rdy    = 4'hF;
        #12;
        chk("rst_vld", 32'(syn_vld), 32'd0);
        chk("rst_in_rdy", 32'(syn_in_rdy), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd1);
        chk("rst_range_err", 32'(range_err), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single range within unit 0
        for (int i = 5; i <= 7; i++) expect_hs(0, i);
        first_hs = -1;
        send(12'h005, 12'h007);
        chk("t1_step_done_low", 32'(step_done), 32'd0);
        wait_done("t1", 0);
        chk("t1_contig", 32'(last_hs - first_hs), 32'd2);
        chk("t1_step_done", 32'(step_done), 32'd1);

        // crossing from unit 0 into unit 1
        expect_hs(0, 10'h3FE);
        expect_hs(0, 10'h3FF);
        expect_hs(1, 10'h000);
        expect_hs(1, 10'h001);
        send(12'h3FE, 12'h401);
        wait_done("t2", 0);

        // two queued ranges stream without a bubble
        syn_rdy = 4'h0;
        expect_hs(0, 10'h010);
        expect_hs(0, 10'h011);
        expect_hs(3, 10'h000);
        send(12'h010, 12'h011);
        send(12'hC00, 12'hC00);
        repeat (3) @(posedge clk);
        #1;
        first_hs = -1;
        syn_rdy = 4'hF;
        wait_done("t3", 0);
        chk("t3_contig", 32'(last_hs - first_hs), 32'd2);

        // enable low blocks input ready
        enable = 1'b0;
        @(negedge clk);
        chk("en_low_in_rdy", 32'(syn_in_rdy), 32'd0);
        @(posedge clk);
        #1;
        enable = 1'b1;

        // unit 2 ready toggling
        syn_rdy = 4'hB;
        for (int i = 0; i < 4; i++) expect_hs(2, i);
        send(12'h800, 12'h803);
        wait_done("t4", 1);

        // inverted range flagged and dropped, next range still served
        send(12'h020, 12'h01F);
        expect_hs(0, 0);
        send(12'h000, 12'h000);
        wait_done("t5", 0);
        chk("t5_range_err", 32'(range_err), 32'd1);

        // reset in the middle of a long range
        for (int i = 0; i < 256; i++) expect_hs(0, 10'h100 + i);
        send(12'h100, 12'h1FF);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(syn_vld), 32'd0);
        chk("mid_rst_step_done", 32'(step_done), 32'd1);
        chk("mid_rst_range_err", 32'(range_err), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_vld", 32'(syn_vld), 32'd0);
        chk("post_rst_step_done", 32'(step_done), 32'd1);
        chk("post_rst_in_rdy", 32'(syn_in_rdy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
